// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with a rename table (busy bit + ROB tag per
// register) and N_CKPT snapshots of that table for mispredict recovery.
module rename_regfile_ckpt #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NREG          = 32,
  parameter int unsigned ROB_WIDTH_BIT = 4,
  parameter int unsigned N_CKPT        = 4,
  localparam int unsigned RIDX         = $clog2(NREG),
  localparam int unsigned CW           = $clog2(N_CKPT),
  localparam int unsigned CNTW         = $clog2(NREG + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_flag,
  input  logic [RIDX-1:0]          ask_reg_id1,
  input  logic [RIDX-1:0]          ask_reg_id2,
  output logic [XLEN-1:0]          ret_val_id1,
  output logic [XLEN-1:0]          ret_val_id2,
  output logic                     dep_rs1,
  output logic                     dep_rs2,
  output logic [ROB_WIDTH_BIT-1:0] ret_ROB_id1,
  output logic [ROB_WIDTH_BIT-1:0] ret_ROB_id2,
  output logic [ROB_WIDTH_BIT-1:0] rs1_id,
  output logic [ROB_WIDTH_BIT-1:0] rs2_id,
  input  logic                     rs1_ready,
  input  logic                     rs2_ready,
  input  logic [XLEN-1:0]          rs1_val,
  input  logic [XLEN-1:0]          rs2_val,
  input  logic [RIDX-1:0]          new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic [RIDX-1:0]          write_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  input  logic [XLEN-1:0]          write_val,
  input  logic                     ckpt_take,
  input  logic [CW-1:0]            ckpt_id,
  input  logic                     recover_valid,
  input  logic [CW-1:0]            recover_id,
  output logic [CNTW-1:0]          busy_count
);

  logic [XLEN-1:0]          regs      [NREG];
  logic [NREG-1:0]          busy;
  logic [ROB_WIDTH_BIT-1:0] tags      [NREG];
  logic [NREG-1:0]          snap_busy [N_CKPT];
  logic [ROB_WIDTH_BIT-1:0] snap_tag  [N_CKPT][NREG];

  logic [NREG-1:0]          busy_nx;
  logic [ROB_WIDTH_BIT-1:0] tag_nx      [NREG];
  logic [NREG-1:0]          snap_busy_nx [N_CKPT];
  logic [ROB_WIDTH_BIT-1:0] snap_tag_nx  [N_CKPT][NREG];
  logic [CNTW-1:0]          count_nx;

  logic                     commit_en;
  logic                     rename_en;
  logic                     hit1;
  logic                     hit2;
  logic [ROB_WIDTH_BIT-1:0] tag1;
  logic [ROB_WIDTH_BIT-1:0] tag2;

  assign commit_en = (write_reg_id != '0);
  assign rename_en = (new_reg_id != '0);

  function automatic logic [CNTW-1:0] count_ones(input logic [NREG-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NREG; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction

  // Operand lookup: a same-cycle rename of the source wins over the table
  always_comb begin
    hit1 = busy[ask_reg_id1];
    tag1 = tags[ask_reg_id1];
    if (rename_en && (ask_reg_id1 == new_reg_id)) begin
      hit1 = 1'b1;
      tag1 = new_ROB_id;
    end
    if (ask_reg_id1 == '0) hit1 = 1'b0;

    hit2 = busy[ask_reg_id2];
    tag2 = tags[ask_reg_id2];
    if (rename_en && (ask_reg_id2 == new_reg_id)) begin
      hit2 = 1'b1;
      tag2 = new_ROB_id;
    end
    if (ask_reg_id2 == '0) hit2 = 1'b0;
  end

  // Operand values come from the ROB while the register is in flight
  always_comb begin
    ret_ROB_id1 = tag1;
    ret_ROB_id2 = tag2;
    rs1_id      = tag1;
    rs2_id      = tag2;
    dep_rs1     = hit1 && !rs1_ready;
    dep_rs2     = hit2 && !rs2_ready;
    ret_val_id1 = hit1 ? rs1_val : ((ask_reg_id1 == '0) ? '0 : regs[ask_reg_id1]);
    ret_val_id2 = hit2 ? rs2_val : ((ask_reg_id2 == '0) ? '0 : regs[ask_reg_id2]);
  end

  // Next rename table and snapshots: clear > recover > normal update
  always_comb begin
    busy_nx      = busy;
    tag_nx       = tags;
    snap_busy_nx = snap_busy;
    snap_tag_nx  = snap_tag;

    if (clear_flag) begin
      busy_nx = '0;
      for (int unsigned r = 0; r < NREG; r++) tag_nx[r] = '0;
      for (int unsigned k = 0; k < N_CKPT; k++) snap_busy_nx[k] = '0;
    end else begin
      // A commit retires the dependency in every snapshot holding its tag
      for (int unsigned k = 0; k < N_CKPT; k++) begin
        if (commit_en && snap_busy[k][write_reg_id] &&
            (snap_tag[k][write_reg_id] == write_ROB_id))
          snap_busy_nx[k][write_reg_id] = 1'b0;
      end

      if (recover_valid) begin
        busy_nx = snap_busy_nx[recover_id];
        tag_nx  = snap_tag[recover_id];
      end else begin
        if (commit_en && busy[write_reg_id] &&
            (tags[write_reg_id] == write_ROB_id) && (write_reg_id != new_reg_id))
          busy_nx[write_reg_id] = 1'b0;
        if (rename_en) begin
          busy_nx[new_reg_id] = 1'b1;
          tag_nx[new_reg_id]  = new_ROB_id;
        end
        if (ckpt_take) begin
          snap_busy_nx[ckpt_id] = busy_nx;
          snap_tag_nx[ckpt_id]  = tag_nx;
        end
      end
    end

    count_nx = count_ones(busy_nx);
  end

  // State update; everything holds while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      busy_count <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      for (int unsigned k = 0; k < N_CKPT; k++) begin
        snap_busy[k] <= '0;
        for (int unsigned r = 0; r < NREG; r++) snap_tag[k][r] <= '0;
      end
    end else if (rdy_in) begin
      busy       <= busy_nx;
      tags       <= tag_nx;
      snap_busy  <= snap_busy_nx;
      snap_tag   <= snap_tag_nx;
      busy_count <= count_nx;
      if (!clear_flag && commit_en) regs[write_reg_id] <= write_val;
    end
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Directed bench for rename_regfile_ckpt: a table of per-cycle inputs with
// hand-computed combinational outputs, plus a reset sequence.
module tb_rename_regfile_ckpt;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_flag;
  logic [4:0]  ask_reg_id1, ask_reg_id2;
  logic [31:0] ret_val_id1, ret_val_id2;
  logic        dep_rs1, dep_rs2;
  logic [3:0]  ret_ROB_id1, ret_ROB_id2, rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  new_reg_id;
  logic [3:0]  new_ROB_id;
  logic [4:0]  write_reg_id;
  logic [3:0]  write_ROB_id;
  logic [31:0] write_val;
  logic        ckpt_take;
  logic [1:0]  ckpt_id;
  logic        recover_valid;
  logic [1:0]  recover_id;
  logic [5:0]  busy_count;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  rename_regfile_ckpt dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .ask_reg_id1(ask_reg_id1), .ask_reg_id2(ask_reg_id2),
    .ret_val_id1(ret_val_id1), .ret_val_id2(ret_val_id2),
    .dep_rs1(dep_rs1), .dep_rs2(dep_rs2),
    .ret_ROB_id1(ret_ROB_id1), .ret_ROB_id2(ret_ROB_id2),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
    .recover_valid(recover_valid), .recover_id(recover_id),
    .busy_count(busy_count)
  );

  typedef struct {
    logic        rdy;
    logic        clr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        r1rdy;
    logic [31:0] r1val;
    logic [4:0]  nreg;
    logic [3:0]  nrob;
    logic [4:0]  wreg;
    logic [3:0]  wrob;
    logic [31:0] wval;
    logic        take;
    logic [1:0]  cid;
    logic        rv;
    logic [1:0]  rid;
    logic [31:0] ev1;
    logic        ed1;
    logic [3:0]  et1;
    logic [31:0] ev2;
    logic        ed2;
    logic [3:0]  et2;
    logic [5:0]  ecnt;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear_flag = 1'b0;
    ask_reg_id1 = '0; ask_reg_id2 = '0;
    rs1_ready = 1'b0; rs1_val = '0;
    rs2_ready = 1'b0; rs2_val = 32'hB2;
    new_reg_id = '0; new_ROB_id = '0;
    write_reg_id = '0; write_ROB_id = '0; write_val = '0;
    ckpt_take = 1'b0; ckpt_id = '0;
    recover_valid = 1'b0; recover_id = '0;
  endtask

  initial begin
    // rdy clr a1 a2 r1rdy r1val nreg nrob wreg wrob wval take cid rv rid | ev1 ed1 et1 ev2 ed2 et2 cnt
    tbl[0]  = '{1,0, 5, 0,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'h0, 0,0,  0};
    tbl[1]  = '{1,0, 1, 2,0,32'h0,   5, 3,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'h0, 0,0,  0};
    tbl[2]  = '{1,0, 5, 5,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  1,3,  32'hB2,1,3,  1};
    tbl[3]  = '{1,0, 5, 0,1,32'hAB,  0, 0,  0,0,32'h0,    0,0,0,0, 32'hAB, 0,3,  32'h0, 0,0,  1};
    tbl[4]  = '{1,0, 7, 7,1,32'h77,  7, 2,  0,0,32'h0,    0,0,0,0, 32'h77, 0,2,  32'hB2,1,2,  1};
    tbl[5]  = '{1,0, 5, 7,0,32'h0,   5, 6,  0,0,32'h0,    0,0,0,0, 32'h0,  1,6,  32'hB2,1,2,  2};
    tbl[6]  = '{1,0, 5, 0,0,32'h0,   0, 0,  5,3,32'h11,   0,0,0,0, 32'h0,  1,6,  32'h0, 0,0,  2};
    tbl[7]  = '{1,0, 5, 7,1,32'h66,  0, 0,  5,6,32'h22,   0,0,0,0, 32'h66, 0,6,  32'hB2,1,2,  2};
    tbl[8]  = '{1,0, 5, 0,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h22, 0,6,  32'h0, 0,0,  1};
    tbl[9]  = '{1,0, 8, 9,0,32'h0,   8, 1,  0,0,32'h0,    1,2,0,0, 32'h0,  1,1,  32'h0, 0,0,  1};
    tbl[10] = '{1,0, 8, 9,1,32'h88,  9, 4,  8,1,32'h5,    0,0,0,0, 32'h88, 0,1,  32'hB2,1,4,  2};
    tbl[11] = '{1,0, 9, 8,0,32'h0,   0, 0,  0,0,32'h0,    0,0,1,2, 32'h0,  1,4,  32'h5, 0,1,  2};
    tbl[12] = '{1,0, 9, 8,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'h5, 0,1,  1};
    tbl[13] = '{1,0, 7, 0,0,32'h0,   0, 0,  0,0,32'h0,    1,1,0,0, 32'h0,  1,2,  32'h0, 0,0,  1};
    tbl[14] = '{1,0,10, 7,0,32'h0,  10, 5,  0,0,32'h0,    1,3,1,1, 32'h0,  1,5,  32'hB2,1,2,  1};
    tbl[15] = '{1,0,10, 7,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'hB2,1,2,  1};
    tbl[16] = '{1,0,11, 7,1,32'hC1, 11, 7,  7,2,32'h70,   0,0,1,1, 32'hC1, 0,7,  32'hB2,1,2,  1};
    tbl[17] = '{1,0, 7,11,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h70, 0,2,  32'h0, 0,0,  0};
    tbl[18] = '{1,0,12, 0,0,32'h0,  12, 8,  0,0,32'h0,    0,0,0,0, 32'h0,  1,8,  32'h0, 0,0,  0};
    tbl[19] = '{1,0,13,12,0,32'h0,  13, 9,  0,0,32'h0,    0,0,0,0, 32'h0,  1,9,  32'hB2,1,8,  1};
    tbl[20] = '{1,1,12,14,0,32'h0,  14,10, 12,8,32'h99,   1,0,0,0, 32'h0,  1,8,  32'hB2,1,10, 2};
    tbl[21] = '{1,0,12,14,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'h0, 0,0,  0};
    tbl[22] = '{0,0,15, 7,0,32'h0,  15,11,  7,0,32'hFF,   0,0,0,0, 32'h0,  1,11, 32'h70,0,0,  0};
    tbl[23] = '{1,0,15, 7,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h0,  0,0,  32'h70,0,0,  0};
    tbl[24] = '{1,0, 0, 0,0,32'h0,   0, 5,  0,0,32'hDEAD, 0,0,0,0, 32'h0,  0,0,  32'h0, 0,0,  0};
    tbl[25] = '{1,0, 0, 0,0,32'h0,   0, 0,  0,0,32'h0,    0,0,1,2, 32'h0,  0,0,  32'h0, 0,0,  0};
    tbl[26] = '{1,0, 8, 7,0,32'h0,   0, 0,  0,0,32'h0,    0,0,0,0, 32'h5,  0,1,  32'h70,0,2,  0};

    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // Table: drive on the falling edge, check just before the rising edge
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_in);
      rst_in        = 1'b0;
      rdy_in        = tbl[i].rdy;
      clear_flag    = tbl[i].clr;
      ask_reg_id1   = tbl[i].a1;
      ask_reg_id2   = tbl[i].a2;
      rs1_ready     = tbl[i].r1rdy;
      rs1_val       = tbl[i].r1val;
      new_reg_id    = tbl[i].nreg;
      new_ROB_id    = tbl[i].nrob;
      write_reg_id  = tbl[i].wreg;
      write_ROB_id  = tbl[i].wrob;
      write_val     = tbl[i].wval;
      ckpt_take     = tbl[i].take;
      ckpt_id       = tbl[i].cid;
      recover_valid = tbl[i].rv;
      recover_id    = tbl[i].rid;
      #2;
      chk("ret_val_id1", i, ret_val_id1, tbl[i].ev1);
      chk("dep_rs1",     i, 32'(dep_rs1), 32'(tbl[i].ed1));
      chk("ret_ROB_id1", i, 32'(ret_ROB_id1), 32'(tbl[i].et1));
      chk("rs1_id",      i, 32'(rs1_id), 32'(tbl[i].et1));
      chk("ret_val_id2", i, ret_val_id2, tbl[i].ev2);
      chk("dep_rs2",     i, 32'(dep_rs2), 32'(tbl[i].ed2));
      chk("ret_ROB_id2", i, 32'(ret_ROB_id2), 32'(tbl[i].et2));
      chk("rs2_id",      i, 32'(rs2_id), 32'(tbl[i].et2));
      chk("busy_count",  i, 32'(busy_count), 32'(tbl[i].ecnt));
    end

    // Two renames, then a mid-run reset must wipe table, regs and count
    @(negedge clk_in);
    idle_inputs();
    new_reg_id = 5'd20; new_ROB_id = 4'd12;
    @(negedge clk_in);
    new_reg_id = 5'd21; new_ROB_id = 4'd13;
    @(negedge clk_in);
    new_reg_id = '0; new_ROB_id = '0;
    ask_reg_id1 = 5'd20; ask_reg_id2 = 5'd21;
    #2;
    chk("seq_count_two", 100, 32'(busy_count), 32'd2);
    chk("seq_dep20",     100, 32'(dep_rs1), 32'd1);
    chk("seq_tag20",     100, 32'(ret_ROB_id1), 32'd12);
    chk("seq_tag21",     100, 32'(ret_ROB_id2), 32'd13);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    ask_reg_id2 = 5'd7;
    #2;
    chk("rst_count",   101, 32'(busy_count), 32'd0);
    chk("rst_dep20",   101, 32'(dep_rs1), 32'd0);
    chk("rst_tag20",   101, 32'(ret_ROB_id1), 32'd0);
    chk("rst_val7",    101, ret_val_id2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
